// File: rtl/lca_pipe_pkg.sv
// Shared widths and per-stage control bundles for the LCA pipeline.
// Stage registers take CTRL_W = $bits(<stage>_ctrl_t).
package lca_pipe_pkg;

  localparam int LCA_WORD_W = 16;
  localparam int REG_ADDR_W = 3;

  typedef struct packed {
    logic pred_taken;
    logic fetch_ok;
  } if_id_ctrl_t;

  typedef struct packed {
    logic                  rf_we;
    logic                  mem_we;
    logic                  mem_re;
    logic [2:0]            alu_op;
    logic [REG_ADDR_W-1:0] rd;
  } id_rr_ctrl_t;

  typedef struct packed {
    logic                  rf_we;
    logic                  mem_we;
    logic                  mem_re;
    logic [2:0]            alu_op;
    logic                  b_sel;
    logic [REG_ADDR_W-1:0] rd;
  } rr_ex_ctrl_t;

  typedef struct packed {
    logic                  rf_we;
    logic                  mem_we;
    logic                  mem_re;
    logic [REG_ADDR_W-1:0] rd;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic                  rf_we;
    logic                  wb_sel;
    logic [REG_ADDR_W-1:0] rd;
  } mem_wb_ctrl_t;

  localparam int IF_ID_CTRL_W  = $bits(if_id_ctrl_t);
  localparam int ID_RR_CTRL_W  = $bits(id_rr_ctrl_t);
  localparam int RR_EX_CTRL_W  = $bits(rr_ex_ctrl_t);
  localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
  localparam int MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);

  function automatic logic [1:0] occ_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/pipeline_stage_reg_slot.sv
// pipeline_slot: one data+ctrl register with valid, load and clear.
// Control reads as zero whenever the slot is empty.
module pipeline_slot
  import lca_pipe_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter int                CTRL_W     = 8,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld,
  input  logic              clr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (clr) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (ld) begin
      valid_d = 1'b1;
      data_d  = in_data;
      ctrl_d  = in_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= RESET_DATA;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign ctrl  = valid_q ? ctrl_q : '0;

endmodule

// File: rtl/pipeline_stage_reg.sv
// Elastic inter-stage register: main + skid slot, valid/ready handshake.
// Flush is honoured only when LCA_PIPE_FLUSH_EN is defined.
module pipeline_stage_reg
  import lca_pipe_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter int                CTRL_W     = 8,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              main_v, skid_v;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              main_ld, main_clr;
  logic              skid_ld, skid_clr;
  logic              main_from_skid;
  logic              accept, pop, flush_act;
  logic [DATA_W-1:0] main_src_data;
  logic [CTRL_W-1:0] main_src_ctrl;

`ifdef LCA_PIPE_FLUSH_EN
  assign flush_act = flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_act    = 1'b0;
`endif

  assign in_ready  = !skid_v;
  assign out_valid = main_v;
  assign accept    = in_valid & in_ready;
  assign pop       = main_v & out_ready;
  assign occupancy = occ_count(main_v, skid_v);

  always_comb begin
    main_ld        = 1'b0;
    main_clr       = 1'b0;
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    main_from_skid = 1'b0;
    if (flush_act) begin
      main_clr = 1'b0 | 1'b1;
      skid_clr = 1'b1;
    end else if (!main_v || (pop && !skid_v)) begin
      main_ld  = accept;
      main_clr = !accept;
    end else if (pop) begin
      // skid full implies in_ready was low, so no accept competes here
      main_ld        = 1'b1;
      main_from_skid = 1'b1;
      skid_clr       = 1'b1;
    end else if (accept) begin
      skid_ld = 1'b1;
    end
  end

  assign main_src_data = main_from_skid ? skid_data : in_data;
  assign main_src_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

  pipeline_slot #(
    .DATA_W    (DATA_W),
    .CTRL_W    (CTRL_W),
    .RESET_DATA(RESET_DATA)
  ) u_main (
    .clk    (clk),
    .reset  (reset),
    .ld     (main_ld),
    .clr    (main_clr),
    .in_data(main_src_data),
    .in_ctrl(main_src_ctrl),
    .valid  (main_v),
    .data   (out_data),
    .ctrl   (out_ctrl)
  );

  pipeline_slot #(
    .DATA_W    (DATA_W),
    .CTRL_W    (CTRL_W),
    .RESET_DATA(RESET_DATA)
  ) u_skid (
    .clk    (clk),
    .reset  (reset),
    .ld     (skid_ld),
    .clr    (skid_clr),
    .in_data(in_data),
    .in_ctrl(in_ctrl),
    .valid  (skid_v),
    .data   (skid_data),
    .ctrl   (skid_ctrl)
  );

  a_no_orphan_skid: assert property (
    @(posedge clk) disable iff (reset) !(skid_v && !main_v)
  );

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Directed + random checks of pipeline_stage_reg.
// Expectations follow LCA_PIPE_FLUSH_EN when the bench is built with it.
module tb_pipeline_stage_reg;

  localparam logic [15:0] RST_D = 16'hA5A5;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data, out_data;
  logic [7:0]  in_ctrl, out_ctrl;
  logic [1:0]  occ;

  logic        r_in_valid, r_in_ready, r_out_valid, r_out_ready;
  logic [47:0] r_in_data, r_out_data;
  logic [4:0]  r_in_ctrl, r_out_ctrl;
  logic [1:0]  r_occ;

  int checks = 0;
  int errors = 0;

  logic [52:0] sb[$];
  logic [52:0] exp_beat;

  always #5 clk = ~clk;

  pipeline_stage_reg #(
    .DATA_W(16), .CTRL_W(8), .RESET_DATA(RST_D)
  ) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occ)
  );

  pipeline_stage_reg #(
    .DATA_W(48), .CTRL_W(5), .RESET_DATA('0)
  ) u_rnd (
    .clk(clk), .reset(reset),
    .in_valid(r_in_valid), .in_ready(r_in_ready),
    .in_data(r_in_data), .in_ctrl(r_in_ctrl),
    .flush(1'b0),
    .out_valid(r_out_valid), .out_ready(r_out_ready),
    .out_data(r_out_data), .out_ctrl(r_out_ctrl),
    .occupancy(r_occ)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [7:0] c);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'hFFFF; in_ctrl = 8'hFF;
    r_in_valid = 1'b0; r_in_data = '0; r_in_ctrl = '0;
    r_out_ready = 1'b0;
    repeat (3) @(negedge clk);

    // reset state (in_valid held high throughout is ignored)
    chk("rst_ov", 64'(out_valid), 64'(0));
    chk("rst_od", 64'(out_data), 64'(RST_D));
    chk("rst_oc", 64'(out_ctrl), 64'(0));
    chk("rst_ir", 64'(in_ready), 64'(1));
    chk("rst_occ", 64'(occ), 64'(0));
    reset = 1'b0; in_valid = 1'b0;

    // single beat
    push(16'h1234, 8'h81); out_ready = 1'b1;
    @(negedge clk);
    chk("t1_ov", 64'(out_valid), 64'(1));
    chk("t1_od", 64'(out_data), 64'(16'h1234));
    chk("t1_oc", 64'(out_ctrl), 64'(8'h81));
    chk("t1_occ", 64'(occ), 64'(1));
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_ov0", 64'(out_valid), 64'(0));
    chk("t1_oc0", 64'(out_ctrl), 64'(0));
    chk("t1_occ0", 64'(occ), 64'(0));

    // back-to-back stream
    for (int j = 0; j < 18; j++) begin
      if (j < 16) push(16'(j + 1), 8'(j));
      else in_valid = 1'b0;
      @(negedge clk);
      chk("s_ir", 64'(in_ready), 64'(1));
      chk("s_ov", 64'(out_valid), 64'(j < 16));
      if (j < 16) chk("s_od", 64'(out_data), 64'(j + 1));
    end

    // back-pressure: A main, B skid, C held
    out_ready = 1'b0;
    push(16'h00A0, 8'h01);
    @(negedge clk);
    chk("bp_occ1", 64'(occ), 64'(1));
    chk("bp_ir1", 64'(in_ready), 64'(1));
    push(16'h00B0, 8'h02);
    @(negedge clk);
    chk("bp_occ2", 64'(occ), 64'(2));
    chk("bp_ir0", 64'(in_ready), 64'(0));
    push(16'h00C0, 8'h03);
    @(negedge clk);
    chk("bp_hold_d", 64'(out_data), 64'(16'h00A0));
    chk("bp_hold_occ", 64'(occ), 64'(2));
    chk("bp_hold_ir", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_b_d", 64'(out_data), 64'(16'h00B0));
    chk("bp_b_c", 64'(out_ctrl), 64'(8'h02));
    chk("bp_b_occ", 64'(occ), 64'(1));
    chk("bp_b_ir", 64'(in_ready), 64'(1));
    @(negedge clk);
    chk("bp_c_d", 64'(out_data), 64'(16'h00C0));
    chk("bp_c_occ", 64'(occ), 64'(1));
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_end_occ", 64'(occ), 64'(0));

    // flush at occupancy 2 with an incoming beat
    out_ready = 1'b0;
    push(16'h00D0, 8'h44);
    @(negedge clk);
    push(16'h00E0, 8'h55);
    @(negedge clk);
    chk("fl_pre_occ", 64'(occ), 64'(2));
    push(16'h00F0, 8'h66); flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
`ifdef LCA_PIPE_FLUSH_EN
    chk("fl_ov", 64'(out_valid), 64'(0));
    chk("fl_oc", 64'(out_ctrl), 64'(0));
    chk("fl_occ", 64'(occ), 64'(0));
    chk("fl_ir", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    @(negedge clk);
    chk("fl_after_ov", 64'(out_valid), 64'(0));
`else
    chk("nfl_occ", 64'(occ), 64'(2));
    chk("nfl_d", 64'(out_data), 64'(16'h00D0));
    chk("nfl_c", 64'(out_ctrl), 64'(8'h44));
    out_ready = 1'b1;
    @(negedge clk);
    chk("nfl_e", 64'(out_data), 64'(16'h00E0));
    chk("nfl_e_occ", 64'(occ), 64'(1));
    @(negedge clk);
    chk("nfl_drain", 64'(occ), 64'(0));
`endif

    // flush at empty with an accepted beat
    push(16'h0BAD, 8'h77); flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
`ifdef LCA_PIPE_FLUSH_EN
    chk("fla_ov", 64'(out_valid), 64'(0));
    chk("fla_oc", 64'(out_ctrl), 64'(0));
`else
    chk("nfla_ov", 64'(out_valid), 64'(1));
    chk("nfla_od", 64'(out_data), 64'(16'h0BAD));
`endif
    @(negedge clk);
    chk("fla_end_occ", 64'(occ), 64'(0));

    // reset at occupancy 2
    out_ready = 1'b0;
    push(16'h1111, 8'h11);
    @(negedge clk);
    push(16'h2222, 8'h22);
    @(negedge clk);
    chk("rs_pre_occ", 64'(occ), 64'(2));
    push(16'h3333, 8'h33); reset = 1'b1;
    @(negedge clk);
    chk("rs_ov", 64'(out_valid), 64'(0));
    chk("rs_od", 64'(out_data), 64'(RST_D));
    chk("rs_oc", 64'(out_ctrl), 64'(0));
    chk("rs_ir", 64'(in_ready), 64'(1));
    chk("rs_occ", 64'(occ), 64'(0));
    reset = 1'b0; in_valid = 1'b0;

    // random traffic with scoreboard on the 48/5 instance
    for (int n = 0; n < 10020; n++) begin
      @(negedge clk);
      chk("r_occ", 64'(r_occ), 64'(sb.size()));
      chk("r_ov", 64'(r_out_valid), 64'(sb.size() != 0));
      if (!r_out_valid) chk("r_bub_c", 64'(r_out_ctrl), 64'(0));
      if (n < 10000) begin
        r_in_valid  = ($urandom_range(0, 9) < 7);
        r_out_ready = ($urandom_range(0, 9) < 6);
        r_in_data   = {16'($urandom), $urandom};
        r_in_ctrl   = 5'($urandom);
      end else begin
        r_in_valid  = 1'b0;
        r_out_ready = 1'b1;
      end
      if (r_out_valid && r_out_ready) begin
        if (sb.size() == 0) begin
          chk("r_extra", 64'(1), 64'(0));
        end else begin
          exp_beat = sb.pop_front();
          chk("r_data", 64'(r_out_data), 64'(exp_beat[52:5]));
          chk("r_ctrl", 64'(r_out_ctrl), 64'(exp_beat[4:0]));
        end
      end
      if (r_in_valid && r_in_ready) sb.push_back({r_in_data, r_in_ctrl});
    end
    chk("r_drained", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
